multicycle_ctrl: RTL and testbench

Moore-style multi-cycle control FSM for the MIPS datapath. It replaces single-cycle decode with IF/ID/EX/MEM/WB sequencing over a shared ALU and a single variable-latency memory port with a req/ready handshake. It sits beside the datapath, takes opcode/func from the instruction register and zero from the ALU, and drives every datapath enable and mux select. ALUCtrl values come from the shared ALUOp_* encodings.

---
 rtl/multicycle_ctrl_if.sv | 27 ++
 rtl/multicycle_ctrl.sv | 296 +++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_ctrl_if.sv
// Memory-port bundle between the multi-cycle controller and the shared memory.
//
// Handshake: the controller raises mem_req (with exactly one of MemRead or
// MemWrite) and holds it, unchanged, until the memory answers. mem_ready is
// looked at only while mem_req=1. A cycle with mem_req=1 and mem_ready=1
// completes the access. The controller may drop mem_req without completion
// only when it is reset or when it abandons the access after a wait timeout.
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_ready;
  logic MemRead;
  logic MemWrite;

  modport master (
    output mem_req,
    output MemRead,
    output MemWrite,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  MemRead,
    input  MemWrite,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EX/MEM/WB over a shared ALU
// and a single variable-latency memory port. It drives every datapath enable
// and mux select, and exposes the current state for debug.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  multicycle_ctrl_if.master mem,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic [1:0] RegDst,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [4:0] ALUCtrl,
  output logic [1:0] DatatoReg,
  output logic [1:0] PC_sel,
  output logic       ExtOp,
  output logic       instr_done,
  output logic       illegal_instr,
  output logic       mem_timeout,
  output logic [3:0] state
);

  // State encodings
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_ALUWB  = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEMRD  = 4'd6;
  localparam logic [3:0] S_MEMWB  = 4'd7;
  localparam logic [3:0] S_MEMWR  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;

  // Shared ALU operation codes
  localparam logic [4:0] ALUOP_AND = 5'd0;
  localparam logic [4:0] ALUOP_OR  = 5'd1;
  localparam logic [4:0] ALUOP_ADD = 5'd2;
  localparam logic [4:0] ALUOP_SUB = 5'd6;
  localparam logic [4:0] ALUOP_SLT = 5'd7;
  localparam logic [4:0] ALUOP_SLL = 5'd8;
  localparam logic [4:0] ALUOP_SRL = 5'd9;
  localparam logic [4:0] ALUOP_SRA = 5'd10;
  localparam logic [4:0] ALUOP_LUI = 5'd11;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_SLT  = 6'h2A;

  // The counter only has to reach MEM_TIMEOUT-1: the wait that would make it
  // MEM_TIMEOUT is the one that trips the trap.
  localparam int CW       = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
  localparam int LIMIT_M1 = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CW-1:0] WAIT_LAST = LIMIT_M1[CW-1:0];

  logic [3:0]    state_q, state_d;
  logic          illegal_instr_q, illegal_instr_d;
  logic          mem_timeout_q, mem_timeout_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  logic       mem_req_c, mem_read_c, mem_write_c;
  logic       is_r_alu, is_i_alu, is_load, is_store;
  logic       is_beq, is_bne, is_j, is_jal, is_jr;
  logic [4:0] alu_op;
  logic       ext_op;
  logic       wait_expired;

  // Instruction decode from the held IR fields
  always_comb begin
    is_r_alu = 1'b0;
    is_i_alu = 1'b0;
    is_load  = 1'b0;
    is_store = 1'b0;
    is_beq   = 1'b0;
    is_bne   = 1'b0;
    is_j     = 1'b0;
    is_jal   = 1'b0;
    is_jr    = 1'b0;
    alu_op   = ALUOP_ADD;
    ext_op   = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_ADD, FN_ADDU: begin is_r_alu = 1'b1; alu_op = ALUOP_ADD; end
          FN_SUB, FN_SUBU: begin is_r_alu = 1'b1; alu_op = ALUOP_SUB; end
          FN_AND:          begin is_r_alu = 1'b1; alu_op = ALUOP_AND; end
          FN_OR:           begin is_r_alu = 1'b1; alu_op = ALUOP_OR;  end
          FN_SLT:          begin is_r_alu = 1'b1; alu_op = ALUOP_SLT; end
          FN_SLL:          begin is_r_alu = 1'b1; alu_op = ALUOP_SLL; end
          FN_SRL:          begin is_r_alu = 1'b1; alu_op = ALUOP_SRL; end
          FN_SRA:          begin is_r_alu = 1'b1; alu_op = ALUOP_SRA; end
          FN_JR:           is_jr = 1'b1;
          default:         ;
        endcase
      end
      OP_ADDI: begin is_i_alu = 1'b1; alu_op = ALUOP_ADD; ext_op = 1'b1; end
      OP_SLTI: begin is_i_alu = 1'b1; alu_op = ALUOP_SLT; ext_op = 1'b1; end
      OP_ORI:  begin is_i_alu = 1'b1; alu_op = ALUOP_OR;  ext_op = 1'b0; end
      OP_LUI:  begin is_i_alu = 1'b1; alu_op = ALUOP_LUI; ext_op = 1'b1; end
      OP_LB, OP_LW: is_load  = 1'b1;
      OP_SB, OP_SW: is_store = 1'b1;
      OP_BEQ:  is_beq = 1'b1;
      OP_BNE:  is_bne = 1'b1;
      OP_J:    is_j   = 1'b1;
      OP_JAL:  is_jal = 1'b1;
      default: ;
    endcase
  end

  assign wait_expired = (MEM_TIMEOUT != 0) && (wait_cnt_q == WAIT_LAST);

  // Next state and per-state control outputs; mem_ready completion wins over the timeout
  always_comb begin
    state_d         = state_q;
    illegal_instr_d = illegal_instr_q;
    mem_timeout_d   = mem_timeout_q;
    mem_req_c       = 1'b0;
    mem_read_c      = 1'b0;
    mem_write_c     = 1'b0;
    IRWrite         = 1'b0;
    PCWrite         = 1'b0;
    RegWrite        = 1'b0;
    RegDst          = 2'b00;
    ALUSrcA         = 1'b0;
    ALUSrcB         = 2'b00;
    ALUCtrl         = ALUOP_AND;
    DatatoReg       = 2'b00;
    PC_sel          = 2'b00;
    ExtOp           = 1'b0;
    instr_done      = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_req_c  = 1'b1;
        mem_read_c = 1'b1;
        ALUSrcB    = 2'b01;
        ALUCtrl    = ALUOP_ADD;
        if (mem.mem_ready) begin
          IRWrite = 1'b1;
          PCWrite = 1'b1;
          state_d = S_DECODE;
        end else if (wait_expired) begin
          mem_timeout_d = 1'b1;
          state_d       = S_TRAP;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        ALUCtrl = ALUOP_ADD;
        if (is_r_alu || is_i_alu)     state_d = S_EXEC;
        else if (is_load || is_store) state_d = S_ADDR;
        else if (is_beq || is_bne)    state_d = S_BRANCH;
        else if (is_j || is_jal || is_jr) state_d = S_JUMP;
        else begin
          illegal_instr_d = 1'b1;
          state_d         = S_TRAP;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUCtrl = alu_op;
        if (is_i_alu) begin
          ALUSrcB = 2'b10;
          ExtOp   = ext_op;
        end
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        RegDst     = is_i_alu ? 2'b00 : 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        ExtOp   = 1'b1;
        ALUCtrl = ALUOP_ADD;
        state_d = is_load ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        mem_req_c  = 1'b1;
        mem_read_c = 1'b1;
        if (mem.mem_ready) begin
          state_d = S_MEMWB;
        end else if (wait_expired) begin
          mem_timeout_d = 1'b1;
          state_d       = S_TRAP;
        end
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        DatatoReg  = 2'b01;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWR: begin
        mem_req_c   = 1'b1;
        mem_write_c = 1'b1;
        if (mem.mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_FETCH;
        end else if (wait_expired) begin
          mem_timeout_d = 1'b1;
          state_d       = S_TRAP;
        end
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUCtrl    = ALUOP_SUB;
        PC_sel     = 2'b01;
        PCWrite    = is_beq ? zero : ~zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PC_sel  = is_jr ? 2'b11 : 2'b10;
        if (is_jal) begin
          RegWrite  = 1'b1;
          RegDst    = 2'b10;
          DatatoReg = 2'b10;
        end
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_IDLE;
    endcase
  end

  // Wait counter: restarts on every state change, counts unanswered request cycles
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (mem_req_c && !mem.mem_ready) begin
      wait_cnt_d = wait_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  // State, sticky flags and wait counter registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q         <= S_IDLE;
      illegal_instr_q <= 1'b0;
      mem_timeout_q   <= 1'b0;
      wait_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      illegal_instr_q <= illegal_instr_d;
      mem_timeout_q   <= mem_timeout_d;
      wait_cnt_q      <= wait_cnt_d;
    end
  end

  assign mem.mem_req    = mem_req_c;
  assign mem.MemRead    = mem_read_c;
  assign mem.MemWrite   = mem_write_c;
  assign illegal_instr  = illegal_instr_q;
  assign mem_timeout    = mem_timeout_q;
  assign state          = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of single instructions with zero-wait
// memory, then hand-written sequences for wait states, traps and resets.
module tb_multicycle_ctrl;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_ALUWB  = 4'd4;
  localparam logic [3:0] S_ADDR   = 4'd5;
  localparam logic [3:0] S_MEMRD  = 4'd6;
  localparam logic [3:0] S_MEMWB  = 4'd7;
  localparam logic [3:0] S_MEMWR  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;
  localparam logic [3:0] S_TRAP   = 4'd11;

  localparam logic [4:0] A_AND = 5'd0;
  localparam logic [4:0] A_OR  = 5'd1;
  localparam logic [4:0] A_ADD = 5'd2;
  localparam logic [4:0] A_SUB = 5'd6;
  localparam logic [4:0] A_SLT = 5'd7;
  localparam logic [4:0] A_SLL = 5'd8;
  localparam logic [4:0] A_SRL = 5'd9;
  localparam logic [4:0] A_SRA = 5'd10;
  localparam logic [4:0] A_LUI = 5'd11;

  // clock / reset
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic [5:0] opcode, func;
  logic       zero;
  logic       IRWrite, PCWrite, RegWrite, ALUSrcA, ExtOp, instr_done;
  logic [1:0] RegDst, ALUSrcB, DatatoReg, PC_sel;
  logic [4:0] ALUCtrl;
  logic       illegal_instr, mem_timeout;
  logic [3:0] state;

  multicycle_ctrl_if mif();

  multicycle_ctrl #(.MEM_TIMEOUT(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .mem           (mif),
    .opcode        (opcode),
    .func          (func),
    .zero          (zero),
    .IRWrite       (IRWrite),
    .PCWrite       (PCWrite),
    .RegWrite      (RegWrite),
    .RegDst        (RegDst),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ALUCtrl       (ALUCtrl),
    .DatatoReg     (DatatoReg),
    .PC_sel        (PC_sel),
    .ExtOp         (ExtOp),
    .instr_done    (instr_done),
    .illegal_instr (illegal_instr),
    .mem_timeout   (mem_timeout),
    .state         (state)
  );

  logic [21:0] ctrl_all;
  assign ctrl_all = {mif.mem_req, mif.MemRead, mif.MemWrite, IRWrite, PCWrite,
                     RegWrite, RegDst, ALUSrcA, ALUSrcB, ALUCtrl, DatatoReg,
                     PC_sel, ExtOp, instr_done};

  // scoreboard
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    string      name;
    logic [5:0] op;
    logic [5:0] fn;
    logic       z;
    logic [3:0] st3;     // state two cycles after FETCH
    logic       srca;
    logic [1:0] srcb;
    logic [4:0] alu;
    logic       ext;
    logic [3:0] st_last; // state in the instr_done cycle
    logic       pcw;
    logic [1:0] pcsel;
    logic       rw;
    logic [1:0] rdst;
    logic [1:0] d2r;
    int         lat;
  } vec_t;

  vec_t vq[$];

  // driver: one instruction with zero-wait memory, starting in the FETCH cycle
  task automatic run_vec(input vec_t v);
    int lat;
    lat = -1;
    @(negedge clk);
    opcode = v.op; func = v.fn; zero = v.z; mif.mem_ready = 1'b1;
    #1;
    chk({v.name, ":fetch"}, 32'({state, mif.mem_req, mif.MemRead, IRWrite, PCWrite, PC_sel, ALUSrcB, ALUCtrl}),
        32'({S_FETCH, 1'b1, 1'b1, 1'b1, 1'b1, 2'b00, 2'b01, A_ADD}));
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (c == 1)
        chk({v.name, ":decode"}, 32'({state, ALUSrcB, ALUCtrl, RegWrite, PCWrite, instr_done}),
            32'({S_DECODE, 2'b11, A_ADD, 1'b0, 1'b0, 1'b0}));
      if (c == 2)
        chk({v.name, ":exec"}, 32'({state, ALUSrcA, ALUSrcB, ALUCtrl, ExtOp}),
            32'({v.st3, v.srca, v.srcb, v.alu, v.ext}));
      if (instr_done) begin
        lat = c + 1;
        chk({v.name, ":done"}, 32'({state, PCWrite, PC_sel, RegWrite, RegDst, DatatoReg}),
            32'({v.st_last, v.pcw, v.pcsel, v.rw, v.rdst, v.d2r}));
        break;
      end
    end
    chk({v.name, ":latency"}, 32'(lat), 32'(v.lat));
  endtask

  // driver: assert reset for one cycle, check cleared outputs, release
  task automatic do_reset(input string name);
    @(negedge clk);
    rstn = 1'b0;
    mif.mem_ready = 1'b0;
    #1;
    chk({name, ":in_reset"}, 32'({state, ctrl_all, illegal_instr, mem_timeout}), 32'({S_IDLE, 22'd0, 2'b00}));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk({name, ":released"}, 32'(state), 32'(S_IDLE));
  endtask

  vec_t addu_v;

  initial begin
    int irw, lat, bad;
    rstn = 1'b0; opcode = 6'h00; func = 6'h00; zero = 1'b0; mif.mem_ready = 1'b0;

    //                name     op     fn     z     st3       srca  srcb   alu    ext   last      pcw   pcsel  rw    rdst   d2r  lat
    vq.push_back(vec_t'{"addu", 6'h00, 6'h21, 1'b0, S_EXEC,   1'b1, 2'b00, A_ADD, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"subu", 6'h00, 6'h23, 1'b0, S_EXEC,   1'b1, 2'b00, A_SUB, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"add",  6'h00, 6'h20, 1'b0, S_EXEC,   1'b1, 2'b00, A_ADD, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"sub",  6'h00, 6'h22, 1'b0, S_EXEC,   1'b1, 2'b00, A_SUB, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"and",  6'h00, 6'h24, 1'b0, S_EXEC,   1'b1, 2'b00, A_AND, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"or",   6'h00, 6'h25, 1'b0, S_EXEC,   1'b1, 2'b00, A_OR,  1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"slt",  6'h00, 6'h2A, 1'b0, S_EXEC,   1'b1, 2'b00, A_SLT, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"sll",  6'h00, 6'h00, 1'b0, S_EXEC,   1'b1, 2'b00, A_SLL, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"srl",  6'h00, 6'h02, 1'b0, S_EXEC,   1'b1, 2'b00, A_SRL, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"sra",  6'h00, 6'h03, 1'b0, S_EXEC,   1'b1, 2'b00, A_SRA, 1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b01, 2'b00, 4});
    vq.push_back(vec_t'{"addi", 6'h08, 6'h3F, 1'b0, S_EXEC,   1'b1, 2'b10, A_ADD, 1'b1, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 4});
    vq.push_back(vec_t'{"ori",  6'h0D, 6'h00, 1'b0, S_EXEC,   1'b1, 2'b10, A_OR,  1'b0, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 4});
    vq.push_back(vec_t'{"lui",  6'h0F, 6'h00, 1'b0, S_EXEC,   1'b1, 2'b10, A_LUI, 1'b1, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 4});
    vq.push_back(vec_t'{"slti", 6'h0A, 6'h00, 1'b0, S_EXEC,   1'b1, 2'b10, A_SLT, 1'b1, S_ALUWB,  1'b0, 2'b00, 1'b1, 2'b00, 2'b00, 4});
    vq.push_back(vec_t'{"lw",   6'h23, 6'h00, 1'b0, S_ADDR,   1'b1, 2'b10, A_ADD, 1'b1, S_MEMWB,  1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 5});
    vq.push_back(vec_t'{"lb",   6'h20, 6'h00, 1'b0, S_ADDR,   1'b1, 2'b10, A_ADD, 1'b1, S_MEMWB,  1'b0, 2'b00, 1'b1, 2'b00, 2'b01, 5});
    vq.push_back(vec_t'{"sw",   6'h2B, 6'h00, 1'b0, S_ADDR,   1'b1, 2'b10, A_ADD, 1'b1, S_MEMWR,  1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4});
    vq.push_back(vec_t'{"sb",   6'h28, 6'h00, 1'b0, S_ADDR,   1'b1, 2'b10, A_ADD, 1'b1, S_MEMWR,  1'b0, 2'b00, 1'b0, 2'b00, 2'b00, 4});
    vq.push_back(vec_t'{"beq1", 6'h04, 6'h00, 1'b1, S_BRANCH, 1'b1, 2'b00, A_SUB, 1'b0, S_BRANCH, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 3});
    vq.push_back(vec_t'{"bne1", 6'h05, 6'h00, 1'b1, S_BRANCH, 1'b1, 2'b00, A_SUB, 1'b0, S_BRANCH, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 3});
    vq.push_back(vec_t'{"beq0", 6'h04, 6'h00, 1'b0, S_BRANCH, 1'b1, 2'b00, A_SUB, 1'b0, S_BRANCH, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00, 3});
    vq.push_back(vec_t'{"bne0", 6'h05, 6'h00, 1'b0, S_BRANCH, 1'b1, 2'b00, A_SUB, 1'b0, S_BRANCH, 1'b1, 2'b01, 1'b0, 2'b00, 2'b00, 3});
    vq.push_back(vec_t'{"j",    6'h02, 6'h00, 1'b0, S_JUMP,   1'b0, 2'b00, A_AND, 1'b0, S_JUMP,   1'b1, 2'b10, 1'b0, 2'b00, 2'b00, 3});
    vq.push_back(vec_t'{"jal",  6'h03, 6'h00, 1'b0, S_JUMP,   1'b0, 2'b00, A_AND, 1'b0, S_JUMP,   1'b1, 2'b10, 1'b1, 2'b10, 2'b10, 3});
    vq.push_back(vec_t'{"jr",   6'h00, 6'h08, 1'b0, S_JUMP,   1'b0, 2'b00, A_AND, 1'b0, S_JUMP,   1'b1, 2'b11, 1'b0, 2'b00, 2'b00, 3});
    addu_v = vq[0];

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("por", 32'({state, ctrl_all, illegal_instr, mem_timeout}), 32'({S_IDLE, 22'd0, 2'b00}));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("por_idle", 32'(state), 32'(S_IDLE));

    // table-driven instructions, zero-wait memory
    foreach (vq[i]) run_vec(vq[i]);

    // lw: 3 waits in FETCH, 2 in MEMRD
    irw = 0; lat = -1;
    opcode = 6'h23; func = 6'h00;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      mif.mem_ready = (c == 3) || (c == 8);
      #1;
      irw += int'(IRWrite);
      if (c == 0) chk("lw_wait:fetch", 32'({state, mif.mem_req, IRWrite}), 32'({S_FETCH, 1'b1, 1'b0}));
      if (c == 6) chk("lw_wait:memrd", 32'({state, mif.mem_req, mif.MemRead, mif.MemWrite}), 32'({S_MEMRD, 3'b110}));
      if (instr_done) begin
        lat = c + 1;
        chk("lw_wait:memwb", 32'({state, RegWrite, RegDst, DatatoReg}), 32'({S_MEMWB, 1'b1, 2'b00, 2'b01}));
        break;
      end
    end
    chk("lw_wait:irwrite_pulses", 32'(irw), 32'd1);
    chk("lw_wait:latency", 32'(lat), 32'd10);

    // sw with mem_ready never arriving: trap after 4 wait cycles
    opcode = 6'h2B;
    bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      mif.mem_ready = (c == 0);
      #1;
      if (instr_done) bad++;
      if (c == 3) chk("sw_to:memwr", 32'({state, mif.mem_req, mif.MemWrite}), 32'({S_MEMWR, 2'b11}));
      if (c == 6) chk("sw_to:last_wait", 32'({state, mif.mem_req, mem_timeout}), 32'({S_MEMWR, 1'b1, 1'b0}));
      if (c == 7) chk("sw_to:trap", 32'({state, ctrl_all, mem_timeout, illegal_instr}), 32'({S_TRAP, 22'd0, 1'b1, 1'b0}));
    end
    chk("sw_to:no_retire", 32'(bad), 32'd0);
    do_reset("sw_to_rst");

    // sw with mem_ready on the 4th wait cycle: completes, no trap
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      mif.mem_ready = (c == 0) || (c == 6);
      #1;
      if (c == 6) chk("sw_edge:retire", 32'({state, instr_done, mif.mem_req, mem_timeout}), 32'({S_MEMWR, 1'b1, 1'b1, 1'b0}));
    end
    run_vec(addu_v);
    chk("sw_edge:no_flag", 32'(mem_timeout), 32'd0);

    // illegal opcode: trap with all controls low, reset clears it
    opcode = 6'h3F; func = 6'h00;
    @(negedge clk); mif.mem_ready = 1'b1; #1;
    @(negedge clk); #1;
    chk("ill:decode", 32'({state, illegal_instr}), 32'({S_DECODE, 1'b0}));
    @(negedge clk); #1;
    chk("ill:trap", 32'({state, illegal_instr, mem_timeout}), 32'({S_TRAP, 1'b1, 1'b0}));
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      mif.mem_ready = 1'(c);
      #1;
      if (ctrl_all != 22'd0 || state != S_TRAP || illegal_instr != 1'b1) bad++;
    end
    chk("ill:hold20", 32'(bad), 32'd0);
    do_reset("ill_rst");
    run_vec(addu_v);

    // reset mid-wait: mem_req drops without a clock edge
    opcode = 6'h2B; func = 6'h00;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      mif.mem_ready = (c == 0);
      #1;
    end
    chk("rst_wait:pre", 32'({state, mif.mem_req}), 32'({S_MEMWR, 1'b1}));
    #1 rstn = 1'b0;
    #1;
    chk("rst_wait:async", 32'({state, mif.mem_req, mif.MemWrite}), 32'({S_IDLE, 2'b00}));
    @(negedge clk);
    rstn = 1'b1;
    #1;
    chk("rst_wait:idle", 32'(state), 32'(S_IDLE));
    run_vec(addu_v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
